// File: rtl/half_duplex_port_pkg.sv
// Shared types and counter widths for the half-duplex bus endpoint.
// Counters are sized for the largest legal TURN (15) and MAX_BURST (255).
package half_duplex_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_RELEASE = 2'd2
  } hdp_state_e;

  localparam int BCNT_W = 8;
  localparam int TCNT_W = 4;

  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] cnt,
                                                input logic [TCNT_W-1:0] lim);
    return (cnt >= lim) ? cnt : cnt + TCNT_W'(1);
  endfunction

endpackage

// File: rtl/half_duplex_port_bidi_pad_cell.sv
// Tristate driver plus input tap for the shared bus; no protocol logic here.
module bidi_pad_cell #(
  parameter int WIDTH = 8
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] pad
);

  assign pad = oe ? dout : {WIDTH{1'bz}};
  assign din = pad;

endmodule

// File: rtl/half_duplex_port.sv
// Half-duplex bus endpoint: yields to a priority peer, sends bursts, captures peer words.
// States: IDLE waits for a quiet bus | DRIVE owns the bus | RELEASE holds high-Z for TURN cycles.
module half_duplex_port
  import half_duplex_port_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TURN      = 2,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] bus,
  output logic             dir,
  output logic             stb_out,
  input  logic             peer_dir,
  input  logic             peer_stb,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             collision
);

  localparam logic [TCNT_W-1:0] TURN_C   = TCNT_W'(TURN);
  localparam logic [TCNT_W-1:0] REL_LAST = TCNT_W'(TURN - 1);
  localparam logic [BCNT_W-1:0] MAXB_C   = BCNT_W'(MAX_BURST);

  hdp_state_e        state_q, state_d;
  logic [TCNT_W-1:0] quiet_q, quiet_d;
  logic [TCNT_W-1:0] rcnt_q, rcnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [WIDTH-1:0]  bus_in;
  logic              stb_q, stb_d;
  logic              rx_valid_q, rx_valid_d;
  logic              coll_q, coll_d;
  logic              accept;

  bidi_pad_cell #(.WIDTH(WIDTH)) u_pad (
    .oe   (dir),
    .dout (dout_q),
    .din  (bus_in),
    .pad  (bus)
  );

  assign dir       = (state_q == ST_DRIVE);
  assign stb_out   = stb_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign collision = coll_q;

  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    bcnt_d     = bcnt_q;
    dout_d     = dout_q;
    stb_d      = 1'b0;
    coll_d     = 1'b0;
    tx_ready   = 1'b0;
    accept     = 1'b0;
    quiet_d    = peer_dir ? '0 : sat_inc(quiet_q, TURN_C);
    rx_valid_d = peer_dir && peer_stb && !dir;
    rx_data_d  = rx_valid_d ? bus_in : rx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid && (quiet_q == TURN_C) && !peer_dir) begin
          state_d = ST_DRIVE;
          bcnt_d  = '0;
        end
      end
      ST_DRIVE: begin
        tx_ready = !peer_dir && (bcnt_q < MAXB_C);
        accept   = tx_valid && tx_ready;
        if (accept) begin
          dout_d = tx_data;
          stb_d  = 1'b1;
          bcnt_d = bcnt_q + BCNT_W'(1);
        end else begin
          // Idle source, full burst or a peer grab all end ownership.
          state_d = ST_RELEASE;
          rcnt_d  = '0;
          coll_d  = peer_dir;
        end
      end
      ST_RELEASE: begin
        if (rcnt_q == REL_LAST) state_d = ST_IDLE;
        else                    rcnt_d  = rcnt_q + TCNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      quiet_q    <= '0;
      rcnt_q     <= '0;
      bcnt_q     <= '0;
      dout_q     <= '0;
      stb_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      quiet_q    <= quiet_d;
      rcnt_q     <= rcnt_d;
      bcnt_q     <= bcnt_d;
      dout_q     <= dout_d;
      stb_q      <= stb_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      coll_q     <= coll_d;
    end
  end

endmodule

// File: tb/tb_half_duplex_port.sv
// Scoreboard bench for half_duplex_port: a window-based ownership model predicts
// dir/tx_ready/collision, and queued TX/RX words are matched by a separate monitor.
module tb_half_duplex_port;
  localparam int WIDTH     = 8;
  localparam int TURN      = 2;
  localparam int MAX_BURST = 16;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  wire  [WIDTH-1:0] bus;
  logic             dir, stb_out, tx_ready, rx_valid, collision;
  logic             peer_dir = 1'b0, peer_stb = 1'b0, tx_valid = 1'b0;
  logic [WIDTH-1:0] tx_data = '0, peer_data = '0, rx_data;

  int   errors = 0, checks = 0, cyc = 0;
  exp_t tx_q[$], rx_q[$];
  int   bursts[$];
  int   cur_burst = 0, dir_high = 0, max_ov = 0, acc_cnt = 0;
  bit   exp_dir = 1'b0, exp_coll = 1'b0;

  assign bus = (peer_dir && peer_stb) ? peer_data : {WIDTH{1'bz}};

  half_duplex_port #(.WIDTH(WIDTH), .TURN(TURN), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dir(dir), .stb_out(stb_out),
    .peer_dir(peer_dir), .peer_stb(peer_stb), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .collision(collision)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s at cycle %0d", name, what, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dir(input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (dir) return;
    end
    flag("wait_dir", "dir never rose");
  endtask

  // Reference model: ownership decided from run lengths of quiet-bus and
  // released-bus cycles; outputs are predicted one cycle ahead.
  initial begin
    bit exp_ready, acc;
    int peer_run, dir_run, burst;
    peer_run = 0; dir_run = 0; burst = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_q.delete();
        rx_q.delete();
        peer_run = 0; dir_run = 0; burst = 0;
        exp_dir  = 1'b0;
        exp_coll = 1'b0;
      end else begin
        exp_ready = exp_dir && !peer_dir && (burst < MAX_BURST);
        chk("dir", dir, exp_dir);
        chk("tx_ready", tx_ready, exp_ready);
        chk("collision", collision, exp_coll);
        acc = tx_valid && exp_ready;
        if (acc) begin
          tx_q.push_back('{data: tx_data, due: cyc + 1});
          burst++;
          acc_cnt++;
        end
        if (peer_dir && peer_stb && !exp_dir)
          rx_q.push_back('{data: peer_data, due: cyc + 1});
        peer_run = peer_dir ? 0 : peer_run + 1;
        dir_run  = exp_dir ? 0 : dir_run + 1;
        exp_coll = exp_dir && peer_dir;
        if (exp_dir) exp_dir = acc;
        else if (tx_valid && peer_run > TURN && dir_run > TURN) begin
          exp_dir = 1'b1;
          burst   = 0;
        end
      end
    end
  end

  initial begin
    exp_t e;
    bit   prev_dir;
    int   ov;
    prev_dir = 1'b0; ov = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_dir  = 1'b0;
        cur_burst = 0;
        ov        = 0;
      end else begin
        while (tx_q.size() > 0 && tx_q[0].due < cyc) begin
          e = tx_q.pop_front();
          flag("tx_missing", "accepted word never presented");
        end
        while (rx_q.size() > 0 && rx_q[0].due < cyc) begin
          e = rx_q.pop_front();
          flag("rx_missing", "peer word never captured");
        end
        if (stb_out) begin
          chk("stb_needs_dir", dir, 1'b1);
          cur_burst++;
          if (tx_q.size() == 0) flag("tx_extra", "stb_out with no accepted word");
          else begin
            e = tx_q.pop_front();
            chk("tx_latency", cyc, e.due);
            chk("tx_word", bus, e.data);
          end
        end
        if (rx_valid) begin
          if (rx_q.size() == 0) flag("rx_extra", "rx_valid with no peer word");
          else begin
            e = rx_q.pop_front();
            chk("rx_latency", cyc, e.due);
            chk("rx_word", rx_data, e.data);
          end
        end
        if (prev_dir && !dir) begin
          bursts.push_back(cur_burst);
          cur_burst = 0;
        end
        if (dir) dir_high++;
        ov = (dir && peer_dir) ? ov + 1 : 0;
        if (ov > max_ov) max_ov = ov;
        prev_dir = dir;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, guard, base, ep;

    // Reset with a word already offered and a quiet bus.
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5; peer_dir = 1'b0;
    repeat (3) tick();
    chk("rst_dir", dir, 1'b0);
    chk("rst_stb", stb_out, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, '0);
    chk("rst_collision", collision, 1'b0);
    rst = 1'b0;
    rel = cyc;
    // quiet reaches TURN after TURN edges; dir rises on the edge after that.
    wait_dir(20);
    chk("acquire_latency", cyc - rel, TURN + 1);
    chk("a5_ready", tx_ready, 1'b1);
    tick();
    tx_valid = 1'b0;
    chk("a5_stb", stb_out, 1'b1);
    chk("a5_bus", bus, 8'hA5);
    tick();
    chk("a5_release_dir", dir, 1'b0);
    tick();
    chk("a5_hold_dir", dir, 1'b0);

    // 20 words against a 16-word burst limit.
    repeat (4) tick();
    bursts.delete();
    acc_cnt = 0; guard = 0;
    tx_valid = 1'b1;
    while (acc_cnt < 20 && guard < 300) begin
      tx_data = 8'h40 + 8'(acc_cnt);
      tick();
      guard++;
    end
    tx_valid = 1'b0;
    chk("burst_total", acc_cnt, 20);
    repeat (6) tick();
    chk("burst_count", bursts.size(), 2);
    if (bursts.size() >= 2) begin
      chk("burst1_len", bursts[0], MAX_BURST);
      chk("burst2_len", bursts[1], 20 - MAX_BURST);
    end

    // Peer-driven receive, with and without strobe.
    peer_dir = 1'b1;
    tick();
    peer_stb = 1'b1; peer_data = 8'h3C;
    tick();
    chk("rx_pulse", rx_valid, 1'b1);
    chk("rx_data_3c", rx_data, 8'h3C);
    peer_stb = 1'b0; peer_data = 8'h55;
    tick();
    chk("rx_no_pulse", rx_valid, 1'b0);
    chk("rx_data_held", rx_data, 8'h3C);
    peer_dir = 1'b0;
    repeat (3) tick();

    // Peer grabs the bus on our third DRIVE cycle.
    tx_valid = 1'b1; tx_data = 8'h90;
    wait_dir(20);
    tick();
    tx_data = 8'h91;
    tick();
    peer_dir = 1'b1; tx_data = 8'h92;
    @(negedge clk);
    chk("coll_ready", tx_ready, 1'b0);
    @(posedge clk); #1;
    chk("coll_pulse", collision, 1'b1);
    chk("coll_dir", dir, 1'b0);
    tx_valid = 1'b0;
    repeat (3) tick();
    chk("coll_overlap", max_ov, 1);
    peer_dir = 1'b0;
    repeat (3) tick();

    // Peer toggling every other cycle keeps the bus from ever going quiet.
    peer_dir = 1'b1; tx_valid = 1'b1;
    tick(); tick();
    base = dir_high;
    for (int i = 0; i < 40; i++) begin
      peer_dir = (i % 2) == 0;
      tick();
    end
    chk("toggle_dir", dir_high - base, 0);
    peer_dir = 1'b0; tx_valid = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a burst.
    tx_valid = 1'b1; tx_data = 8'hC1;
    wait_dir(20);
    tick();
    tx_data = 8'hC2;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_dir", dir, 1'b0);
    chk("midrst_stb", stb_out, 1'b0);
    rst = 1'b0; tx_valid = 1'b0;
    repeat (4) tick();

    // Randomized peer activity and local traffic.
    ep = 0;
    for (int i = 0; i < 400; i++) begin
      if (ep > 0) begin
        peer_dir = 1'b1;
        ep--;
      end else if ($urandom_range(0, 9) == 0) begin
        peer_dir = 1'b1;
        ep = $urandom_range(0, 5);
      end else peer_dir = 1'b0;
      peer_stb  = peer_dir && !exp_dir && ($urandom_range(0, 1) == 1);
      peer_data = WIDTH'($urandom);
      tx_valid  = $urandom_range(0, 9) < 7;
      tx_data   = WIDTH'($urandom);
      tick();
    end

    peer_dir = 1'b0; peer_stb = 1'b0; tx_valid = 1'b0;
    repeat (8) tick();
    chk("tx_q_drained", tx_q.size(), 0);
    chk("rx_q_drained", rx_q.size(), 0);
    chk("max_overlap", max_ov, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
